// File: rtl/pong_vga_renderer_if.sv
// Game-logic/VGA-pin bundle for pong_vga_renderer: sprite positions in, sync/colour/strobes out.
interface pong_vga_renderer_if #(
    parameter int unsigned RGB_W = 4
) ();
    logic [9:0]       bola_x;
    logic [9:0]       bola_y;
    logic [9:0]       barra_e_y;
    logic [9:0]       barra_d_y;
    logic             HSync;
    logic             VSync;
    logic [RGB_W-1:0] R;
    logic [RGB_W-1:0] G;
    logic [RGB_W-1:0] B;
    logic             pix_ce;
    logic             frame_start;

    modport master (
        output bola_x, bola_y, barra_e_y, barra_d_y,
        input  HSync, VSync, R, G, B, pix_ce, frame_start
    );

    modport slave (
        input  bola_x, bola_y, barra_e_y, barra_d_y,
        output HSync, VSync, R, G, B, pix_ce, frame_start
    );
endinterface

// File: rtl/pong_vga_renderer.sv
// VGA timing generator and Pong sprite compositor (paddles, round ball, walls).
// Optional dashed centre net enabled by defining PONG_NET_EN.
module pong_vga_renderer #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned PADDLE_W  = 15,
    parameter int unsigned PADDLE_H  = 80,
    parameter int unsigned BALL_SIZE = 20,
    parameter int unsigned WALL_H    = 6,
    parameter int unsigned RGB_W     = 4
) (
    input logic              Clock,
    input logic              Reset_n,
    pong_vga_renderer_if.slave vga
);
    localparam int unsigned H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [10:0]   H_LAST   = 11'(H_TOT - 1);
    localparam logic [10:0]   V_LAST   = 11'(V_TOT - 1);
    localparam logic [10:0]   HV       = 11'(H_VISIBLE);
    localparam logic [10:0]   VV       = 11'(V_VISIBLE);
    localparam logic [10:0]   HS_FIRST = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0]   HS_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0]   VS_FIRST = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0]   VS_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [10:0]   PW       = 11'(PADDLE_W);
    localparam logic [10:0]   PH       = 11'(PADDLE_H);
    localparam logic [10:0]   RP_FIRST = 11'(H_VISIBLE - PADDLE_W);
    localparam logic [10:0]   BS       = 11'(BALL_SIZE);
    localparam logic [11:0]   BS12     = 12'(BALL_SIZE);
    localparam logic [24:0]   R2       = 25'(BALL_SIZE * BALL_SIZE);
    localparam logic [10:0]   WH       = 11'(WALL_H);
    localparam logic [10:0]   WB_FIRST = 11'(V_VISIBLE - WALL_H);

    logic [DW-1:0] div_q, div_d;
    logic          ce_q;
    logic [10:0]   hpos_q, vpos_q;
    logic [10:0]   bx_q, by_q, ey_q, dy_q;
    logic          hsync_q, vsync_q;
    logic          fg_q;

    logic          hpos_last, vpos_last;
    logic          active, hsync_on, vsync_on;
    logic          hit_left, hit_right, hit_ball, hit_wall, hit_net, fg_d;
    logic [10:0]   dx, dyb;
    logic [11:0]   tx, ty, ax, ay;
    logic [23:0]   sqx, sqy;

    assign div_d     = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    assign hpos_last = (hpos_q == H_LAST);
    assign vpos_last = (vpos_q == V_LAST);

    // ce_q tracks (div_q == CLK_DIV-1) but stays low while in reset
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            div_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            ce_q  <= (div_d == DIV_LAST);
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            hpos_q <= '0;
            vpos_q <= '0;
            bx_q   <= '0;
            by_q   <= '0;
            ey_q   <= '0;
            dy_q   <= '0;
        end else if (ce_q) begin
            hpos_q <= hpos_last ? '0 : hpos_q + 11'd1;
            if (hpos_last) begin
                vpos_q <= vpos_last ? '0 : vpos_q + 11'd1;
            end
            // Shadow positions at the start of vertical blanking so a frame never tears
            if (hpos_q == '0 && vpos_q == VV) begin
                bx_q <= {1'b0, vga.bola_x};
                by_q <= {1'b0, vga.bola_y};
                ey_q <= {1'b0, vga.barra_e_y};
                dy_q <= {1'b0, vga.barra_d_y};
            end
        end
    end

    always_comb begin
        active    = (hpos_q < HV) && (vpos_q < VV);
        hsync_on  = (hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST);
        vsync_on  = (vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST);
        hit_left  = (hpos_q < PW) && (vpos_q >= ey_q) && (vpos_q < ey_q + PH);
        hit_right = (hpos_q >= RP_FIRST) && (hpos_q < HV)
                    && (vpos_q >= dy_q) && (vpos_q < dy_q + PH);
        hit_wall  = (vpos_q < WH) || ((vpos_q >= WB_FIRST) && (vpos_q < VV));

        // Disc test on doubled offsets from the box centre: |2d+1-S| per axis
        dx  = hpos_q - bx_q;
        dyb = vpos_q - by_q;
        tx  = {dx, 1'b0} + 12'd1;
        ty  = {dyb, 1'b0} + 12'd1;
        ax  = (tx >= BS12) ? tx - BS12 : BS12 - tx;
        ay  = (ty >= BS12) ? ty - BS12 : BS12 - ty;
        sqx = 24'(ax) * 24'(ax);
        sqy = 24'(ay) * 24'(ay);
        hit_ball = (hpos_q >= bx_q) && (hpos_q < bx_q + BS)
                   && (vpos_q >= by_q) && (vpos_q < by_q + BS)
                   && ((25'(sqx) + 25'(sqy)) <= R2);
`ifdef PONG_NET_EN
        hit_net = ((hpos_q == HV / 11'd2 - 11'd1) || (hpos_q == HV / 11'd2)) && !vpos_q[3];
`else
        hit_net = 1'b0;
`endif
        fg_d = active && (hit_left || hit_right || hit_ball || hit_wall || hit_net);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            fg_q    <= 1'b0;
        end else if (ce_q) begin
            hsync_q <= hsync_on ? SYNC_POL : ~SYNC_POL;
            vsync_q <= vsync_on ? SYNC_POL : ~SYNC_POL;
            fg_q    <= fg_d;
        end
    end

    assign vga.HSync       = hsync_q;
    assign vga.VSync       = vsync_q;
    assign vga.R           = {RGB_W{fg_q}};
    assign vga.G           = {RGB_W{fg_q}};
    assign vga.B           = {RGB_W{fg_q}};
    assign vga.pix_ce      = ce_q;
    assign vga.frame_start = ce_q && hpos_last && vpos_last;
endmodule
